// File: rtl/pc_gen.sv
// Fetch program-counter unit for an RV32I front end: issues the fetch PC over a
// valid/ready handshake and absorbs stalls, branch/jump redirects and trap entries.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              PC_INC       = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            REDIRECT_VALID,
  input  logic [XLEN-1:0] REDIRECT_PC,
  input  logic            TRAP_VALID,
  input  logic [XLEN-1:0] TRAP_PC,
  input  logic            FETCH_READY,
  output logic            FETCH_VALID,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS,
  output logic            FETCH_STALE,
  output logic            MISALIGN
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic            hs;
  logic            redir_any;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] seq_tgt;

  // Bit 0 is never a legal fetch address bit; bit 1 survives so MISALIGN can flag it.
  function automatic logic [XLEN-1:0] align_tgt(input logic [XLEN-1:0] t);
    return {t[XLEN-1:1], 1'b0};
  endfunction

  assign hs        = fetch_valid_q & FETCH_READY;
  assign redir_any = TRAP_VALID | REDIRECT_VALID;
  assign redir_tgt = TRAP_VALID ? align_tgt(TRAP_PC) : align_tgt(REDIRECT_PC);
  assign pc_plus   = pc_q + XLEN'(PC_INC);
  assign seq_tgt   = (state_q == ST_PEND) ? pend_pc_q : pc_plus;

  always_comb begin
    state_d       = state_q;
    fetch_valid_d = fetch_valid_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    if (state_q == ST_BOOT) begin
      state_d       = ST_RUN;
      fetch_valid_d = ~STALL;
    end else if (hs) begin
      pc_d          = redir_any ? redir_tgt : seq_tgt;
      state_d       = ST_RUN;
      fetch_valid_d = ~STALL;
    end else if (fetch_valid_q) begin
      // Request still outstanding: PC must hold, so park the newest target.
      if (redir_any) begin
        pend_pc_d = redir_tgt;
        state_d   = ST_PEND;
      end
    end else begin
      if (redir_any) begin
        pc_d = redir_tgt;
      end
      fetch_valid_d = ~STALL;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= ST_BOOT;
      fetch_valid_q <= 1'b0;
      pc_q          <= RESET_VECTOR;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      pc_q          <= pc_d;
    end
  end

  // Pending target is qualified by state, so it needs no reset.
  always_ff @(posedge CLK) begin
    pend_pc_q <= pend_pc_d;
  end

  assign FETCH_VALID = fetch_valid_q;
  assign PC          = pc_q;
  assign PC_PLUS     = pc_plus;
  assign FETCH_STALE = (state_q == ST_PEND);
  assign MISALIGN    = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic,
// all compared against a behavioural fetch-PC model.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic        tv;
  logic [31:0] tpc;
  logic        rdy;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        fetch_stale;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit          m_boot;
  bit          m_fv;
  bit          m_pend;
  logic [31:0] m_pc;
  logic [31:0] m_ppc;
  bit          saw_300;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .PC_INC(4)) dut (
    .CLK(clk), .RST(rst), .STALL(stall),
    .REDIRECT_VALID(rv), .REDIRECT_PC(rpc),
    .TRAP_VALID(tv), .TRAP_PC(tpc),
    .FETCH_READY(rdy), .FETCH_VALID(fetch_valid), .PC(pc),
    .PC_PLUS(pc_plus), .FETCH_STALE(fetch_stale), .MISALIGN(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at that edge.
  task automatic model_edge();
    bit          hs;
    bit          any;
    logic [31:0] tgt;
    hs  = m_fv & rdy;
    any = tv | rv;
    tgt = tv ? (tpc & ~32'd1) : (rpc & ~32'd1);
    if (!rst) begin
      m_boot = 1; m_pc = 32'h0; m_fv = 0; m_pend = 0;
    end else if (m_boot) begin
      m_boot = 0; m_fv = ~stall;
    end else if (hs) begin
      if (any)         m_pc = tgt;
      else if (m_pend) m_pc = m_ppc;
      else             m_pc = m_pc + 32'd4;
      m_pend = 0;
      m_fv   = ~stall;
    end else if (m_fv) begin
      if (any) begin
        m_ppc  = tgt;
        m_pend = 1;
      end
    end else begin
      if (any) m_pc = tgt;
      m_fv = ~stall;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
    check_eq("pc",          pc,                   m_pc);
    check_eq("pc_plus",     pc_plus,              m_pc + 32'd4);
    check_eq("fetch_stale", {31'd0, fetch_stale}, {31'd0, m_pend});
    check_eq("misalign",    {31'd0, misalign},    {31'd0, (m_pc[1:0] != 2'b00)});
    if (fetch_valid && pc == 32'h300) saw_300 = 1;
    rv = 0;
    tv = 0;
  endtask

  // Redirect taken together with a handshake so the next PC is exactly tgt.
  task automatic jump_to(input logic [31:0] tgt);
    rdy = 1; stall = 0; rv = 1; rpc = tgt;
    step();
  endtask

  initial begin
    rst = 0; stall = 0; rv = 0; rpc = 0; tv = 0; tpc = 0; rdy = 1;
    m_boot = 1; m_fv = 0; m_pend = 0; m_pc = 0; m_ppc = 0; saw_300 = 0;

    // Reset and boot
    step(); step();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_fv", {31'd0, fetch_valid}, 32'd0);
    rst = 1;
    step();
    check_eq("boot_fv", {31'd0, fetch_valid}, 32'd1);
    check_eq("boot_pc", pc, 32'h0);
    step(); check_eq("seq_4", pc, 32'h4);
    step(); check_eq("seq_8", pc, 32'h8);
    step(); check_eq("seq_c", pc, 32'hc);

    // Backpressure
    jump_to(32'h10);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_pc", pc, 32'h10);
      check_eq("bp_fv", {31'd0, fetch_valid}, 32'd1);
    end
    rdy = 1; step();
    check_eq("bp_after", pc, 32'h14);

    // Redirect then trap while a request is pending
    jump_to(32'h20);
    rdy = 0; rv = 1; rpc = 32'h80; step();
    check_eq("pend_stale1", {31'd0, fetch_stale}, 32'd1);
    tv = 1; tpc = 32'h100; step();
    check_eq("pend_stale2", {31'd0, fetch_stale}, 32'd1);
    check_eq("pend_hold", pc, 32'h20);
    rdy = 1; step();
    check_eq("pend_pc", pc, 32'h100);
    check_eq("pend_clr", {31'd0, fetch_stale}, 32'd0);

    // Redirect coincident with handshake, bit 0 cleared, bit 1 kept
    jump_to(32'h41);
    check_eq("rd41_pc", pc, 32'h40);
    check_eq("rd41_mis", {31'd0, misalign}, 32'd0);
    check_eq("rd41_stale", {31'd0, fetch_stale}, 32'd0);
    jump_to(32'h42);
    check_eq("rd42_pc", pc, 32'h42);
    check_eq("rd42_mis", {31'd0, misalign}, 32'd1);

    // Stall at handshake with wrap, then redirect while idle
    jump_to(32'hFFFF_FFFC);
    stall = 1; step();
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_fv", {31'd0, fetch_valid}, 32'd0);
    rv = 1; rpc = 32'h200; step();
    check_eq("idle_rd_pc", pc, 32'h200);
    check_eq("idle_rd_fv", {31'd0, fetch_valid}, 32'd0);
    stall = 0; step();
    check_eq("resume_fv", {31'd0, fetch_valid}, 32'd1);
    check_eq("resume_pc", pc, 32'h200);

    // Reset while a target is pending
    rdy = 0; rv = 1; rpc = 32'h300; step();
    check_eq("rp_stale", {31'd0, fetch_stale}, 32'd1);
    rst = 0; step();
    check_eq("rp_pc", pc, 32'h0);
    check_eq("rp_fv", {31'd0, fetch_valid}, 32'd0);
    check_eq("rp_stale0", {31'd0, fetch_stale}, 32'd0);
    rst = 1; rdy = 1;
    for (int i = 0; i < 4; i++) step();
    check_eq("rp_no300", {31'd0, saw_300}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) != 0);
      stall = ($urandom_range(0, 3) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      rv    = ($urandom_range(0, 4) == 0);
      tv    = ($urandom_range(0, 9) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + {29'd0, 3'($urandom)} : $urandom;
      tpc   = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
